// File: rtl/my_rgb2gray_wsum_pipe.sv
// my_rgb2gray_wsum_pipe: 3-stage weighted-sum pixel reducer with saturation and valid/ready back-pressure.
// Define RGB2GRAY_ROUND_EN for round-half-up of the shifted sum; the default build truncates.
module my_rgb2gray_wsum_pipe #(
   parameter int NCH    = 3,
   parameter int DIN_W  = 8,
   parameter int COEF_W = 17,
   parameter int FRAC_W = 16,
   parameter int DOUT_W = 8,
   parameter int SB_W   = 2
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    coef_load,
   input  logic [NCH*COEF_W-1:0]   coef_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NCH*DIN_W-1:0]    din,
   input  logic [SB_W-1:0]         sb_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DOUT_W-1:0]       dout,
   output logic [SB_W-1:0]         sb_out
);
   localparam int PW    = DIN_W + COEF_W;
   localparam int SUM_W = PW + $clog2(NCH) + 1;
   localparam logic [SUM_W-1:0] MAX = SUM_W'((1 << DOUT_W) - 1);
`ifdef RGB2GRAY_ROUND_EN
   localparam logic [SUM_W-1:0] RND = (SUM_W'(1) << FRAC_W) >> 1;
`else
   localparam logic [SUM_W-1:0] RND = '0;
`endif
   logic [NCH*COEF_W-1:0] coef_reg, c1;
   logic [NCH*DIN_W-1:0]  d1;
   logic [SB_W-1:0]       sb1, sb2;
   logic                  v1, v2;
   logic [PW-1:0]         p2 [NCH];
   logic [SUM_W-1:0]      sum, shifted;
   logic [DOUT_W-1:0]     sat;
   logic                  adv_1, adv_2, adv_out;
   assign adv_out  = !out_valid || out_ready;
   assign adv_2    = !v2 || adv_out;
   assign adv_1    = !v1 || adv_2;
   assign in_ready = adv_1;
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++) sum = sum + SUM_W'(p2[i]);
   end
   assign shifted = (sum + RND) >> FRAC_W;
   assign sat     = (shifted > MAX) ? MAX[DOUT_W-1:0] : shifted[DOUT_W-1:0];
   // a pixel takes the coefficient being loaded in its own acceptance cycle
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         coef_reg  <= '0;
         c1        <= '0;
         d1        <= '0;
         sb1       <= '0;
         sb2       <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         dout      <= '0;
         sb_out    <= '0;
         for (int i = 0; i < NCH; i++) p2[i] <= '0;
      end else begin
         if (coef_load) coef_reg <= coef_in;
         if (adv_1) v1 <= in_valid;
         if (adv_1 && in_valid) begin
            d1  <= din;
            sb1 <= sb_in;
            c1  <= coef_load ? coef_in : coef_reg;
         end
         if (adv_2) v2 <= v1;
         if (adv_2 && v1) begin
            sb2 <= sb1;
            for (int i = 0; i < NCH; i++)
               p2[i] <= PW'(d1[i*DIN_W +: DIN_W]) * PW'(c1[i*COEF_W +: COEF_W]);
         end
         if (adv_out) out_valid <= v2;
         if (adv_out && v2) begin
            dout   <= sat;
            sb_out <= sb2;
         end
      end
   end
endmodule

// File: tb/tb_my_rgb2gray_wsum_pipe.sv
// tb_my_rgb2gray_wsum_pipe: directed scoreboard bench for the weighted-sum pixel pipeline.
module tb_my_rgb2gray_wsum_pipe;
   logic        ap_clk = 0, ap_rst = 1, coef_load = 0, in_valid = 0, out_ready = 1;
   logic [50:0] coef_in = '0;
   logic [23:0] din = '0;
   logic [1:0]  sb_in = '0, sb_out;
   logic        in_ready, out_valid;
   logic [7:0]  dout;
   int          errors = 0, checks = 0, outs = 0;
   logic [9:0]  exp_q [$];
   logic [50:0] coef_m = '0;
   logic        prev_stall = 0, done = 0;
   logic [7:0]  prev_dout;
   logic [1:0]  prev_sb;
   localparam logic [50:0] DEF_COEF = {17'd7471, 17'd38470, 17'd19595};

   my_rgb2gray_wsum_pipe dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .coef_load(coef_load), .coef_in(coef_in),
      .in_valid(in_valid), .in_ready(in_ready), .din(din), .sb_in(sb_in),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sb_out(sb_out)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [9:0] model(input logic [23:0] px, input logic [50:0] cf, input logic [1:0] s);
      longint acc = 0;
      for (int i = 0; i < 3; i++) acc += longint'(px[i*8 +: 8]) * longint'(cf[i*17 +: 17]);
`ifdef RGB2GRAY_ROUND_EN
      acc += 32768;
`endif
      acc = acc >>> 16;
      if (acc > 255) acc = 255;
      return {s, acc[7:0]};
   endfunction

   // scoreboard: push on accept, pop on output transfer, occupancy-based in_ready, stall stability
   always @(negedge ap_clk) begin
      if (ap_rst) begin
         exp_q.delete();
         coef_m = '0;
         prev_stall = 0;
      end else begin
         logic [9:0] e;
         chk("in_ready", in_ready, !(exp_q.size() == 3 && !out_ready));
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_dout", dout, prev_dout);
            chk("hold_sb", sb_out, prev_sb);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("dout", dout, e[7:0]);
               chk("sb_out", sb_out, e[9:8]);
               outs++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(din, coef_load ? coef_in : coef_m, sb_in));
         if (coef_load) coef_m = coef_in;
         prev_stall = out_valid && !out_ready;
         prev_dout = dout;
         prev_sb = sb_out;
      end
   end

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic send(input logic [23:0] px, input logic [1:0] s, input logic ld, input logic [50:0] cf);
      in_valid = 1;
      din = px;
      sb_in = s;
      coef_load = ld;
      if (ld) coef_in = cf;
      for (int t = 0; ; t++) begin
         @(negedge ap_clk);
         if (in_ready) break;
         if (t == 200) begin
            chk("accept_timeout", in_ready, 1);
            break;
         end
      end
      step();
      in_valid = 0;
      coef_load = 0;
   endtask

   task automatic load(input logic [50:0] cf);
      coef_load = 1;
      coef_in = cf;
      step();
      coef_load = 0;
   endtask

   task automatic drain();
      out_ready = 1;
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int base;
      repeat (3) step();
      ap_rst = 0;
      @(negedge ap_clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_sb_out", sb_out, 0);
      chk("rst_in_ready", in_ready, 1);
      step();
      send(24'hFFFFFF, 2'b01, 0, '0);
      drain();
      load(DEF_COEF);
      // accept-to-output latency with out_ready held high
      in_valid = 1;
      din = 24'hFFFFFF;
      sb_in = 2'b10;
      @(negedge ap_clk);
      chk("lat_accept", in_ready, 1);
      step();
      in_valid = 0;
      @(negedge ap_clk);
      chk("lat_c1", out_valid, 0);
      @(negedge ap_clk);
      chk("lat_c2", out_valid, 0);
      @(negedge ap_clk);
      chk("lat_c3", out_valid, 1);
      chk("lat_dout", dout, 255);
      chk("lat_sb", sb_out, 2'b10);
      step();
      send({8'd0, 8'd0, 8'd100}, 2'b11, 0, '0);
      send({8'd10, 8'd20, 8'd30}, 2'b00, 0, '0);
      drain();
      load({3{17'd65535}});
      send(24'hFFFFFF, 2'b01, 0, '0);
      send(24'h000000, 2'b10, 0, '0);
      drain();
      load(DEF_COEF);
      base = outs;
      fork
         begin
            for (int k = 0; k < 16; k++) send(24'($urandom), 2'($urandom), 0, '0);
            done = 1;
         end
         begin
            while (!done) begin
               step();
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();
      chk("stream_count", outs - base, 16);
      send({3{8'd200}}, 2'b01, 0, '0);
      send({3{8'd200}}, 2'b10, 1, {17'd0, 17'd0, 17'd32768});
      send({3{8'd200}}, 2'b11, 0, '0);
      drain();
      out_ready = 0;
      send(24'h102030, 2'b01, 0, '0);
      send(24'h405060, 2'b10, 0, '0);
      send(24'h708090, 2'b11, 0, '0);
      ap_rst = 1;
      step();
      @(negedge ap_clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      step();
      ap_rst = 0;
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge ap_clk);
         chk("no_stale", out_valid, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
